amo_memory: RTL
===============

# amo_memory

Parametrised data memory with atomic LR/SC support for `NUM_HARTS` requesters, the multi-hart successor to the single-core data memory. Each hart has a valid/ready request channel and a fixed-latency response channel. A round-robin arbiter grants one access per cycle. Per-hart reservation registers implement load-reserved/store-conditional, with cross-hart invalidation.

## Interface
- `NUM_HARTS`, 2: number of request channels (1..8).
- `DEPTH`, 256: memory depth in 32-bit words, power of two.
- `AW`, 32: request address width (byte address).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_HARTS  per-hart request valid.
- `req_ready`  out  NUM_HARTS  per-hart grant; the request is accepted when valid & ready.
- `req_op`  in  2*NUM_HARTS  per-hart op, hart i at [2i+:2]: 00 load, 01 store, 10 LR, 11 SC.
- `req_addr`  in  AW*NUM_HARTS  per-hart byte address, hart i at [AW*i+:AW].
- `req_wdata`  in  32*NUM_HARTS  per-hart store data, hart i at [32i+:32].
- `resp_valid`  out  NUM_HARTS  one-cycle response pulse for hart i.
- `resp_rdata`  out  32*NUM_HARTS  response data; for SC: 0 = success, 1 = failure.

## Operation
- Word index = `req_addr[2 +: log2(DEPTH)]`. Bits [1:0] and higher bits are ignored, so addresses wrap modulo the depth.
- Arbitration: round-robin pointer `last` (log2 NUM_HARTS bits).
  - Priority order is last+1, last+2, … wrapping.
  - Exactly one `req_ready` bit goes high, on the first requesting hart in that order; all bits are low if no hart requests.
  - `req_ready` is combinational from `req_valid` and `last`.
  - On acceptance, `last` <= the granted hart.
- Load: returns `mem[idx]` as it was before this cycle's edge.
- Store: `mem[idx] <= wdata`. The response is returned with `resp_rdata` = 0.
- LR: returns `mem[idx]`. Sets `resv_valid[h]` = 1 and `resv_idx[h]` = idx, replacing any earlier reservation held by hart h.
- SC by hart h:
  - Succeeds iff `resv_valid[h]` && `resv_idx[h]` == idx.
  - On success: write `mem[idx]`, respond 0.
  - On failure: no write, respond 1.
  - Either outcome clears `resv_valid[h]`.
- Invalidation: any store or successful SC to idx clears `resv_valid[j]` for every hart j with `resv_idx[j]` == idx, including the writer's own reservation.
- A hart that keeps `req_valid` low consumes nothing. A hart holding `req_valid` without `req_ready` must keep its op, addr and wdata stable.
- There is no response backpressure. The requester must take the `resp_valid` pulse.

## Timing
- Reset values (asynchronous):
  - `resp_valid` = 0, `resp_rdata` = 0.
  - All `resv_valid` = 0.
  - `last` = NUM_HARTS-1, so hart 0 has first priority.
  - Memory contents are zeroed.
  - `req_ready` follows reset state combinationally.
- Latency is 1 cycle. A request accepted in cycle T (edge at end of T) produces `resp_valid[h]` = 1 and its data during T+1 only.
  - The memory write and reservation updates commit at that same edge.
- Throughput is one access per cycle total. A hart may issue its next request in the cycle its response is visible.
- Read-after-write: a load accepted in T+1 after a store in T returns the new data.
- Only one access is granted per cycle, so there are no same-cycle memory or reservation conflicts.
- Reset asserted mid-operation:
  - Any pending response is dropped; `resp_valid` stays 0 after reset releases.
  - The reservations are lost, so a subsequent SC fails.
- SC with no prior LR fails with 1. A second SC after a successful SC fails with 1.

## Test plan
- Reset, then hart 0 stores 0xDEADBEEF to 0x10 and loads 0x10 -> load response 0xDEADBEEF arrives one cycle after acceptance; the store response is 0.
- Both harts hold `req_valid` for 4 cycles -> grants alternate 0, 1, 0, 1, and each `resp_valid` pulse is exactly one cycle.
- Hart 0 does LR 0x20, then SC 0x20 with data 5 -> SC response 0 and memory reads 5; a second SC to 0x20 responds 1 and memory still reads 5.
- Hart 0 does LR 0x20, hart 1 stores 7 to 0x20, then hart 0 does SC 0x20 with data 9 -> SC responds 1 and memory reads 7.
- Hart 0 does LR 0x20, hart 1 stores to 0x24, then hart 0 does SC 0x20 -> succeeds (0). Address 0x20 + 4*DEPTH aliases to 0x20.
- Hart 0 does LR, reset is pulsed mid-response, then hart 0 does SC to the same address -> no stale `resp_valid`, SC responds 1, and memory reads 0.

Source files
------------

// File: rtl/amo_memory.sv
// Multi-hart data memory with round-robin arbitration and LR/SC reservations.
// Latency: 1 cycle from acceptance to resp_valid pulse; one access per cycle in total.
// Backpressure: req_ready grants a single hart per cycle; responses cannot be stalled.
module amo_memory #(
    parameter int NUM_HARTS = 2,
    parameter int DEPTH     = 256,
    parameter int AW        = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_HARTS-1:0]    req_valid,
    output logic [NUM_HARTS-1:0]    req_ready,
    input  logic [2*NUM_HARTS-1:0]  req_op,
    input  logic [AW*NUM_HARTS-1:0] req_addr,
    input  logic [32*NUM_HARTS-1:0] req_wdata,
    output logic [NUM_HARTS-1:0]    resp_valid,
    output logic [32*NUM_HARTS-1:0] resp_rdata
);

    localparam int IW = $clog2(DEPTH);
    localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_STORE = 2'b01,
        OP_LR    = 2'b10,
        OP_SC    = 2'b11
    } op_e;

    typedef struct packed {
        op_e             op;
        logic [IW-1:0]   idx;
        logic [31:0]     wdata;
    } req_t;

    logic [HW-1:0]        last;
    logic [31:0]          mem [DEPTH];
    logic [NUM_HARTS-1:0] resv_valid;
    logic [NUM_HARTS-1:0] resv_valid_nxt;
    logic [IW-1:0]        resv_idx [NUM_HARTS];

    logic                 fire;
    logic [HW-1:0]        gnt_idx;
    logic [HW-1:0]        cand;
    req_t                 sel;
    logic                 sc_ok;
    logic                 wr_en;
    logic [31:0]          rd_dat;
    logic                 addr_unused;

    // Upper and byte-offset address bits deliberately wrap/ignore.
    assign addr_unused = ^req_addr;

    // Round-robin: search starts at the hart after the last one granted.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        fire      = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_HARTS; k++) begin
            cand = HW'((int'(last) + k) % NUM_HARTS);
            if (!fire && req_valid[cand]) begin
                fire    = 1'b1;
                gnt_idx = cand;
            end
        end
        req_ready[gnt_idx] = fire;
    end

    always_comb begin
        sel = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (req_ready[h]) begin
                sel.op    = op_e'(req_op[2*h +: 2]);
                sel.idx   = req_addr[AW*h+2 +: IW];
                sel.wdata = req_wdata[32*h +: 32];
            end
        end
    end

    always_comb begin
        sc_ok  = resv_valid[gnt_idx] && (resv_idx[gnt_idx] == sel.idx);
        wr_en  = fire && ((sel.op == OP_STORE) || ((sel.op == OP_SC) && sc_ok));
        rd_dat = '0;
        case (sel.op)
            OP_LOAD, OP_LR: rd_dat = mem[sel.idx];
            OP_STORE:       rd_dat = '0;
            OP_SC:          rd_dat = {31'b0, !sc_ok};
            default:        rd_dat = '0;
        endcase

        // Any write kills every matching reservation, the writer's included.
        resv_valid_nxt = resv_valid;
        if (wr_en) begin
            for (int j = 0; j < NUM_HARTS; j++) begin
                if (resv_idx[j] == sel.idx)
                    resv_valid_nxt[j] = 1'b0;
            end
        end
        if (fire && sel.op == OP_LR)
            resv_valid_nxt[gnt_idx] = 1'b1;
        if (fire && sel.op == OP_SC)
            resv_valid_nxt[gnt_idx] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last       <= HW'(NUM_HARTS - 1);
            resp_valid <= '0;
            resp_rdata <= '0;
            resv_valid <= '0;
            for (int j = 0; j < NUM_HARTS; j++)
                resv_idx[j] <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            resp_valid <= req_ready;
            resv_valid <= resv_valid_nxt;
            if (fire) begin
                last <= gnt_idx;
                if (sel.op == OP_LR)
                    resv_idx[gnt_idx] <= sel.idx;
            end
            for (int h = 0; h < NUM_HARTS; h++) begin
                if (req_ready[h])
                    resp_rdata[32*h +: 32] <= rd_dat;
            end
            if (wr_en)
                mem[sel.idx] <= sel.wdata;
        end
    end

endmodule
